tone_synth: RTL
===============

Name: tone_synth

Overview:
- Downstream of the collision tone oscillator; consumes its one-cycle `at_max` tick train.
- The oscillator emits 256 ticks per tone period.
- This block advances an 8-bit phase on each tick and shapes the phase into an 8-bit waveform sample.
- It scales the sample by volume and drives the speaker pin through an 8-bit PWM DAC.
- Goes silent automatically when the tick train stops.

Parameters:
- PHASE_W, 8: phase accumulator width; one tone period = 2^PHASE_W ticks.
- PWM_W, 8: PWM counter/duty width; PWM period = 2^PWM_W clocks.
- IDLE_CYCLES, 512: clocks without a tick before the block declares silence; must be > largest tick spacing (188+1).

Ports:
- clk, input, 1: system clock.
- nRst, input, 1: asynchronous active-low reset.
- at_max, input, 1: tick from oscillator, one-cycle pulse.
- wave_sel, input, 2: waveform select (WAVE_TYPES).
- volume, input, 2: 3 = full, 0 = quietest.
- mute, input, 1: force silence.
- pwm_out, output, 1: speaker drive.
- sample, output, PHASE_W: current scaled sample.
- active, output, 1: tone in progress.
- period_done, output, 1: one-cycle pulse on phase wrap.

Behaviour:
- Reset: all outputs and registers are 0, including phase, idle counter, latched wave/volume, pwm counter and duty.
- Reset mid-tone is immediate silence; the next tone starts at phase 0.

Phase:
- On `at_max`, phase <= phase+1, wrapping 255->0.
- The wrap asserts `period_done` in the cycle after the tick that caused it.

Activity:
- `at_max` sets active=1 next cycle and clears the idle counter.
- Otherwise, while active, the idle counter increments.
- Reaching IDLE_CYCLES-1 clears active, phase, and the idle counter next cycle.
- Tick and timeout in the same cycle: the tick wins.

Wave/volume latching:
- `wave_sel` and `volume` are latched only on a phase wrap or while active=0.
- Mid-period changes therefore take effect at the next period boundary, which avoids audible glitches.

Shaping (registered, 1 cycle after the phase update):
- SQUARE: phase[7] ? 255 : 0.
- SAW: phase.
- TRI: phase[7] ? ~{phase[6:0],1'b0} : {phase[6:0],1'b0}.
- PULSE25: (phase[7:6]==2'b11) ? 255 : 0.

Volume:
- sample = shaped >> (3 - volume), logical shift.
- sample is forced to 0 when active=0 or mute=1.

Latency:
- Tick at cycle t: phase updates at t+1, sample at t+2.

PWM:
- pwm_cnt free-runs every clock and wraps.
- duty <= sample when pwm_cnt==255.
- pwm_out <= (pwm_cnt < duty) & active & ~mute, registered.
- duty 0 gives a constant low; 255 gives high for 255 of 256 clocks.
- `mute` or loss of `active` drops pwm_out on the next clock, without waiting for the period boundary.

Decomposition:
- Shared package holds:
  - `WAVE_TYPES` enum: WAVE_SQUARE=0, WAVE_SAW=1, WAVE_TRI=2, WAVE_PULSE25=3.
  - Default IDLE_CYCLES constant, alongside the existing tone frequency/duration constants.
- One natural sub-module, `pwm_dac`:
  - Parameter PWM_W; inputs clk, nRst, duty, en; output pwm_out.
  - Contains the free-running counter, boundary-latched duty, and output register.
- Phase, activity, latching and shaping remain in `tone_synth`.

Test Plan:
1. Reset → pwm_out=0, sample=0, active=0. Then a single tick → active=1 next cycle and phase=1. No further ticks → active=0 exactly IDLE_CYCLES clocks after the tick, with phase=0.
2. SAW, volume=3, ticks every 110 clocks → sample steps 0,1,2,… two cycles after each tick. After 256 ticks, period_done pulses once and sample returns to 0.
3. SQUARE, volume=3 → sample=0 for phases 0–127 and 255 for phases 128–255. pwm_out is constantly low, then high 255 of 256 clocks once duty latches. Set volume=1 → sample=63, and pwm_out high 63 of 256 clocks.
4. Change wave_sel SAW→TRI at phase 100 → sample continues as SAW until the wrap. At phase 0 after the wrap it is TRI (0), and at phase 64 it is 128.
5. Assert mute mid-tone → pwm_out=0 the next clock and sample=0, while phase keeps advancing. Deassert mute → output resumes at the next PWM boundary.
6. Pulse nRst low at phase 200 while active → all outputs 0 immediately. After release, the first tick gives phase=1, with wave/volume re-latched because active=0.

Source files
------------

// File: rtl/tone_synth_pkg.sv
// Shared definitions for the collision tone path: waveform encodings and
// timing constants used by the oscillator and the tone synthesiser.
package tone_synth_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE  = 2'd0,
    WAVE_SAW     = 2'd1,
    WAVE_TRI     = 2'd2,
    WAVE_PULSE25 = 2'd3
  } WAVE_TYPES;

  // Oscillator timing: ticks per tone period and the widest tick spacing it can produce.
  localparam int TONE_TICKS_PER_PERIOD = 256;
  localparam int TONE_MIN_TICK_SPACING = 24;
  localparam int TONE_MAX_TICK_SPACING = 188;

  localparam int IDLE_CYCLES_DEFAULT = 512;

endpackage

// File: rtl/pwm_dac.sv
// Single-bit PWM DAC: free-running counter, duty sampled once per PWM period,
// registered output that can be gated off immediately by en.
module pwm_dac #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [PWM_W-1:0] duty,
  input  logic             en,
  output logic             pwm_out
);

  logic [PWM_W-1:0] r_cnt;
  logic [PWM_W-1:0] r_duty;
  logic             r_pwm;

  // Duty only changes at the period boundary so each PWM period is clean.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_cnt  <= '0;
      r_duty <= '0;
      r_pwm  <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == '1) begin
        r_duty <= duty;
      end
      r_pwm <= (r_cnt < r_duty) && en;
    end
  end

  assign pwm_out = r_pwm;

endmodule

// File: rtl/tone_synth.sv
// Tone synthesiser: steps a phase on each oscillator tick, shapes and scales
// it into a sample, and drives the speaker through a PWM DAC.
module tone_synth
  import tone_synth_pkg::*;
#(
  parameter int PHASE_W     = 8,
  parameter int PWM_W       = 8,
  parameter int IDLE_CYCLES = IDLE_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               at_max,
  input  logic [1:0]         wave_sel,
  input  logic [1:0]         volume,
  input  logic               mute,
  output logic               pwm_out,
  output logic [PHASE_W-1:0] sample,
  output logic               active,
  output logic               period_done
);

  localparam int IDLE_W = $clog2(IDLE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

  logic [PHASE_W-1:0] r_phase;
  logic [IDLE_W-1:0]  r_idle;
  logic               r_active;
  logic               r_period_done;
  WAVE_TYPES          r_wave;
  logic [1:0]         r_vol;
  logic [PHASE_W-1:0] r_sample;

  logic               w_wrap;
  logic               w_latch;
  logic [PHASE_W-1:0] w_ramp;
  logic [PHASE_W-1:0] w_shaped;
  logic [1:0]         w_shift;
  logic [PWM_W-1:0]   w_duty;

  assign w_wrap  = at_max && (r_phase == '1);
  // Wave/volume only follow the inputs at a period boundary or while silent.
  assign w_latch = w_wrap || !r_active;
  assign w_ramp  = {r_phase[PHASE_W-2:0], 1'b0};
  assign w_shift = 2'd3 - r_vol;

  always_comb begin
    w_shaped = '0;
    case (r_wave)
      WAVE_SQUARE:  w_shaped = {PHASE_W{r_phase[PHASE_W-1]}};
      WAVE_SAW:     w_shaped = r_phase;
      WAVE_TRI:     w_shaped = r_phase[PHASE_W-1] ? ~w_ramp : w_ramp;
      WAVE_PULSE25: w_shaped = {PHASE_W{&r_phase[PHASE_W-1:PHASE_W-2]}};
      default:      w_shaped = '0;
    endcase
  end

  // A tick always beats the idle timeout, so a steady tick train never drops out.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_phase       <= '0;
      r_idle        <= '0;
      r_active      <= 1'b0;
      r_period_done <= 1'b0;
      r_wave        <= WAVE_SQUARE;
      r_vol         <= 2'd0;
      r_sample      <= '0;
    end else begin
      r_period_done <= w_wrap;
      if (at_max) begin
        r_phase  <= r_phase + 1'b1;
        r_active <= 1'b1;
        r_idle   <= '0;
      end else if (r_active) begin
        if (r_idle == IDLE_LAST) begin
          r_active <= 1'b0;
          r_phase  <= '0;
          r_idle   <= '0;
        end else begin
          r_idle <= r_idle + 1'b1;
        end
      end
      if (w_latch) begin
        r_wave <= WAVE_TYPES'(wave_sel);
        r_vol  <= volume;
      end
      r_sample <= (r_active && !mute) ? (w_shaped >> w_shift) : '0;
    end
  end

  assign w_duty = PWM_W'(r_sample);

  pwm_dac #(
    .PWM_W(PWM_W)
  ) u_pwm_dac (
    .clk    (clk),
    .nRst   (nRst),
    .duty   (w_duty),
    .en     (r_active && !mute),
    .pwm_out(pwm_out)
  );

  assign sample      = r_sample;
  assign active      = r_active;
  assign period_done = r_period_done;

endmodule
